// File: rtl/status_pkg.sv
// Shared status codes for the status sequencer and the status decoder.
// The state encoding is the (a, b) code itself.
package status_pkg;

    localparam int MUNICAO_W = 4;

    typedef enum logic [1:0] {
        ST_DESLIGADO  = 2'b00,
        ST_RECARGA    = 2'b01,
        ST_PREPARACAO = 2'b10,
        ST_ATAQUE     = 2'b11
    } estado_t;

endpackage

// File: rtl/controlador_de_status_if.sv
// Operator panel inputs and status outputs of the status sequencer.
// master drives the panel side; slave is the sequencer.
interface controlador_de_status_if;
    import status_pkg::*;

    logic                 liga;
    logic                 disparo;
    logic                 cancela;
    logic                 recarregar;
    logic                 a;
    logic                 b;
    logic                 pronto;
    logic                 tiro;
    logic [MUNICAO_W-1:0] municao;

    modport master (
        output liga, disparo, cancela, recarregar,
        input  a, b, pronto, tiro, municao
    );

    modport slave (
        input  liga, disparo, cancela, recarregar,
        output a, b, pronto, tiro, municao
    );
endinterface

// File: rtl/temporizador_de_fase.sv
// Loadable down-counter with zero flag, shared by all timed phases.
// It saturates at zero; load takes priority over decrement.
module temporizador_de_fase #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         dec,
    input  logic [W-1:0] val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/controlador_de_status.sv
// Status sequencer: DESLIGADO -> PREPARACAO -> ATAQUE -> RECARGA.
// {a, b} is the state register; all outputs are registered.
module controlador_de_status
    import status_pkg::*;
#(
    parameter int PREP_CICLOS    = 8,
    parameter int ATAQUE_CICLOS  = 4,
    parameter int RECARGA_CICLOS = 6,
    parameter int MUNICAO_MAX    = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    controlador_de_status_if.slave bus
);

    localparam int TMAX_PA = (PREP_CICLOS > ATAQUE_CICLOS) ?
                             PREP_CICLOS : ATAQUE_CICLOS;
    localparam int TMAX    = (TMAX_PA > RECARGA_CICLOS) ?
                             TMAX_PA : RECARGA_CICLOS;
    localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0]        T_PREP = TW'(PREP_CICLOS - 1);
    localparam logic [TW-1:0]        T_ATQ  = TW'(ATAQUE_CICLOS - 1);
    localparam logic [TW-1:0]        T_REC  = TW'(RECARGA_CICLOS - 1);
    localparam logic [MUNICAO_W-1:0] M_MAX  = MUNICAO_W'(MUNICAO_MAX);

    estado_t              st, st_n;
    logic                 pronto_q, pronto_n;
    logic                 tiro_q, tiro_n;
    logic [MUNICAO_W-1:0] mun_q, mun_n;
    logic                 ld, dec, zero;
    logic [TW-1:0]        ld_v;
    logic                 tem_mun;

    assign tem_mun = (mun_q != '0);

    temporizador_de_fase #(.W(TW)) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .dec   (dec),
        .val   (ld_v),
        .zero  (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= ST_DESLIGADO;
            pronto_q <= 1'b0;
            tiro_q   <= 1'b0;
            mun_q    <= M_MAX;
        end else begin
            st       <= st_n;
            pronto_q <= pronto_n;
            tiro_q   <= tiro_n;
            mun_q    <= mun_n;
        end
    end

    always_comb begin
        st_n     = st;
        pronto_n = pronto_q;
        tiro_n   = 1'b0;
        mun_n    = mun_q;
        ld       = 1'b0;
        ld_v     = '0;
        dec      = 1'b0;
        unique case (st)
            ST_DESLIGADO: begin
                pronto_n = 1'b0;
                if (bus.recarregar) mun_n = M_MAX;
                if (bus.liga && !bus.cancela && tem_mun) begin
                    st_n = ST_PREPARACAO;
                    ld   = 1'b1;
                    ld_v = T_PREP;
                end
            end
            ST_PREPARACAO: begin
                // abort outranks a simultaneous fire request
                if (bus.cancela || !bus.liga) begin
                    st_n     = ST_DESLIGADO;
                    pronto_n = 1'b0;
                end else if (pronto_q) begin
                    if (bus.disparo && tem_mun) begin
                        st_n     = ST_ATAQUE;
                        ld       = 1'b1;
                        ld_v     = T_ATQ;
                        tiro_n   = 1'b1;
                        mun_n    = mun_q - MUNICAO_W'(1);
                        pronto_n = 1'b0;
                    end
                end else if (zero) begin
                    pronto_n = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_ATAQUE: begin
                if (bus.cancela || zero) begin
                    st_n = ST_RECARGA;
                    ld   = 1'b1;
                    ld_v = T_REC;
                end else begin
                    dec = 1'b1;
                end
            end
            ST_RECARGA: begin
                if (!zero) begin
                    dec = 1'b1;
                end else if (bus.liga && tem_mun) begin
                    st_n = ST_PREPARACAO;
                    ld   = 1'b1;
                    ld_v = T_PREP;
                end else begin
                    st_n = ST_DESLIGADO;
                end
            end
        endcase
    end

    assign bus.a       = st[1];
    assign bus.b       = st[0];
    assign bus.pronto  = pronto_q;
    assign bus.tiro    = tiro_q;
    assign bus.municao = mun_q;

endmodule

// File: doc/controlador_de_status.md
Name: controlador_de_status

Overview:
- Sequences the 2-bit status code (a, b) consumed by the status decoder: DESLIGADO → PREPARACAO → ATAQUE → RECARGA → back.
- Each phase is held for a timed, parameterised number of clock cycles.
- Gated by operator inputs (liga, disparo, cancela) and by an on-board ammunition counter.
- Sits between the operator panel inputs and the status decoder; the (a, b) outputs drive its A and B inputs directly.

Parameters:
- PREP_CICLOS, 8: cycles spent in PREPARACAO before pronto asserts (≥1).
- ATAQUE_CICLOS, 4: cycles spent in ATAQUE per shot (≥1).
- RECARGA_CICLOS, 6: cycles spent in RECARGA after each shot (≥1).
- MUNICAO_MAX, 3: shots available after reset or refill (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- liga  in  1  level: system enable.
- disparo  in  1  level: fire request, sampled only when pronto=1.
- cancela  in  1  level: abort.
- recarregar  in  1  single-cycle refill request, honoured only in DESLIGADO.
- a  out  1  status code MSB, to decoder A.
- b  out  1  status code LSB, to decoder B.
- pronto  out  1  PREPARACAO timer expired; waiting for disparo.
- municao  out  4  remaining shots.
- tiro  out  1  one-cycle pulse on entry to ATAQUE.

Behaviour:
- State encoding is the code itself, so {a, b} = state register with no decode logic:
  - DESLIGADO = 00, PREPARACAO = 10, ATAQUE = 11, RECARGA = 01.
  - RECARGA = 01 makes the decoder drive all three indicators low; this is intended.
- All outputs are registered. A state change is visible on a, b one cycle after the qualifying input is sampled.
- Reset (rst_n=0, immediate, any state including mid-ATAQUE):
  - state = DESLIGADO, timer = 0, pronto = 0, tiro = 0, municao = MUNICAO_MAX.
- One down-counter `timer` is shared by all timed states. Width is clog2(max(PREP, ATAQUE, RECARGA)). It is loaded with N-1 on entry to each timed state.
- DESLIGADO:
  - recarregar=1 → municao = MUNICAO_MAX.
  - liga=1 and cancela=0 and municao>0 → PREPARACAO, timer = PREP_CICLOS-1.
  - liga=1 with municao=0 → stay in DESLIGADO.
- PREPARACAO:
  - cancela=1 or liga=0 → DESLIGADO (highest priority); pronto cleared.
  - timer>0 → timer decrements.
  - timer=0 → pronto=1 (from the next cycle) and the state holds indefinitely until disparo.
  - pronto=1 and disparo=1 → ATAQUE, timer = ATAQUE_CICLOS-1, tiro=1 for one cycle, municao decrements, pronto=0.
  - disparo while pronto=0 is ignored and is not latched.
- ATAQUE:
  - Lasts exactly ATAQUE_CICLOS cycles, then → RECARGA with timer = RECARGA_CICLOS-1.
  - cancela=1 → RECARGA next cycle (shot is already spent; no refund).
  - liga=0 is ignored until RECARGA ends.
- RECARGA:
  - Lasts exactly RECARGA_CICLOS cycles; cancela is ignored.
  - On expiry: liga=1 and municao>0 → PREPARACAO with timer reloaded; otherwise → DESLIGADO.
- Simultaneous events:
  - cancela beats disparo.
  - recarregar outside DESLIGADO is dropped.
- municao never underflows, because entry to ATAQUE requires municao ≥ 1.

Decomposition:
- Shared package `status_pkg`:
  - state localparams: ST_DESLIGADO, ST_PREPARACAO, ST_ATAQUE, ST_RECARGA.
  - MUNICAO_W = 4.
  - The decoder later reuses the same codes.
- Optional sub-module `temporizador_de_fase`: loadable down-counter with zero flag. Everything else is a single always block plus next-state logic.

Test Plan:
- Reset, then liga=1 with defaults → a,b = 10 one cycle later; pronto rises after 8 cycles in PREPARACAO; municao = 3.
- pronto=1, disparo=1 → a,b = 11 for exactly 4 cycles with a tiro pulse of 1 cycle and municao = 2; then 01 for 6 cycles; then 10 again (liga held).
- Fire three shots → after the third RECARGA, a,b = 00 while liga=1. Pulse recarregar → municao = 3, then next cycle a,b = 10.
- cancela asserted in PREPARACAO at timer=3 → a,b = 00 next cycle, pronto=0. cancela during ATAQUE cycle 2 → 01 next cycle, municao still decremented.
- disparo held from PREPARACAO entry → ATAQUE starts only on the cycle after pronto=1. disparo and cancela together at pronto → DESLIGADO, no tiro.
- rst_n dropped mid-ATAQUE (asynchronously, off-edge) → a,b = 00 and municao = 3 immediately, without waiting for clk.
